// File: rtl/frame_row_streamer.sv
// Reads frame rows back from the shared SRAM read port, one row per access,
// and serialises the row's pixels (pixel 0 first) onto a valid/ready stream.
module frame_row_streamer #(
   parameter int ADDR_SIZE_BITS  = 24,
   parameter int WORD_SIZE_BYTES = 3,
   parameter int DATA_SIZE_WORDS = 64,
   parameter int ADDR_STRIDE     = 192,
   parameter int READ_LATENCY    = 1
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         start,
   input  logic [ADDR_SIZE_BITS-1:0]                    base_address,
   input  logic [15:0]                                  num_rows,
   output logic                                         read_enable,
   output logic [ADDR_SIZE_BITS-1:0]                    address,
   input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
   output logic [WORD_SIZE_BYTES*8-1:0]                 pix_data,
   output logic                                         pix_valid,
   input  logic                                         pix_ready,
   output logic                                         pix_last_row,
   output logic                                         pix_last_frame,
   output logic                                         busy,
   output logic                                         done
);

   // state  | meaning
   // IDLE   | waiting for start
   // READ   | read_enable held for READ_LATENCY cycles, then row captured
   // STREAM | presenting buffered pixels on the stream
   // DONE   | one-cycle done pulse, busy already low

   localparam int PIX_W  = WORD_SIZE_BYTES * 8;
   localparam int ROW_W  = PIX_W * DATA_SIZE_WORDS;
   localparam int PX_W   = (DATA_SIZE_WORDS > 1) ? $clog2(DATA_SIZE_WORDS) : 1;
   localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   localparam logic [PX_W-1:0]           LAST_PX  = PX_W'(DATA_SIZE_WORDS - 1);
   localparam logic [LAT_W-1:0]          LAT_LOAD = LAT_W'(READ_LATENCY - 1);
   localparam logic [ADDR_SIZE_BITS-1:0] STRIDE   = ADDR_SIZE_BITS'(ADDR_STRIDE);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_SIZE_BITS-1:0] addr_q, addr_d;
   logic [15:0]               num_rows_q, num_rows_d;
   logic [15:0]               row_q, row_d;
   logic [PX_W-1:0]           px_q, px_d;
   logic [LAT_W-1:0]          lat_q, lat_d;
   logic [ROW_W-1:0]          row_buf_q, row_buf_d;

   logic handshake;
   logic last_px;
   logic last_row;

   assign handshake = (state_q == S_STREAM) && pix_ready;
   assign last_px   = (px_q == LAST_PX);
   assign last_row  = (row_q == num_rows_q - 16'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         num_rows_q <= '0;
         row_q      <= '0;
         px_q       <= '0;
         lat_q      <= '0;
         row_buf_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         num_rows_q <= num_rows_d;
         row_q      <= row_d;
         px_q       <= px_d;
         lat_q      <= lat_d;
         row_buf_q  <= row_buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = (num_rows == 16'd0) ? S_DONE : S_READ;
         S_READ:   if (lat_q == '0) state_d = S_STREAM;
         S_STREAM: if (handshake && last_px) state_d = last_row ? S_DONE : S_READ;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath: latches frame parameters, counts the read wait, advances pixel/row.
   always_comb begin
      addr_d     = addr_q;
      num_rows_d = num_rows_q;
      row_d      = row_q;
      px_d       = px_q;
      lat_d      = lat_q;
      row_buf_d  = row_buf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = base_address;
               num_rows_d = num_rows;
               row_d      = '0;
               px_d       = '0;
               lat_d      = LAT_LOAD;
            end
         end
         S_READ: begin
            if (lat_q == '0) begin
               row_buf_d = read_data;
               px_d      = '0;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_STREAM: begin
            if (handshake) begin
               px_d = px_q + PX_W'(1);
               if (last_px && !last_row) begin
                  row_d  = row_q + 16'd1;
                  addr_d = addr_q + STRIDE;
                  lat_d  = LAT_LOAD;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      read_enable    = 1'b0;
      address        = '0;
      pix_valid      = 1'b0;
      pix_data       = '0;
      pix_last_row   = 1'b0;
      pix_last_frame = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      case (state_q)
         S_READ: begin
            read_enable = 1'b1;
            address     = addr_q;
            busy        = 1'b1;
         end
         S_STREAM: begin
            pix_valid      = 1'b1;
            pix_data       = row_buf_q[int'(px_q)*PIX_W +: PIX_W];
            pix_last_row   = last_px;
            pix_last_frame = last_px && last_row;
            busy           = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_frame_row_streamer.sv
// Self-checking bench for frame_row_streamer: SRAM model driven from the address,
// expected pixel stream built from row/pixel arithmetic and compared per handshake.
module tb_frame_row_streamer;

   localparam int AW     = 24;
   localparam int DW     = 64;
   localparam int STRIDE = 192;
   localparam int PW     = 24;
   localparam int RW     = PW * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_address = '0;
   logic [15:0]   num_rows = '0;
   logic          read_enable;
   logic [AW-1:0] address;
   logic [RW-1:0] read_data;
   logic [PW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready = 1'b0;
   logic          pix_last_row;
   logic          pix_last_frame;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   frame_row_streamer dut (
      .clk(clk), .rst(rst), .start(start), .base_address(base_address),
      .num_rows(num_rows), .read_enable(read_enable), .address(address),
      .read_data(read_data), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_last_row(pix_last_row),
      .pix_last_frame(pix_last_frame), .busy(busy), .done(done)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int data_mode = 0;
   int ready_mode = 0;
   logic [31:0] seed = 32'h1234_5678;

   logic [PW-1:0] hs_pix[$];
   bit            hs_lr[$];
   bit            hs_lf[$];
   int            hs_cyc[$];
   logic [AW-1:0] rd_addr[$];
   int            done_cyc[$];
   int            re_cnt;
   int            valid_cnt;
   int            first_valid_cyc;

   // Mode 0: pixel k of any row is k. Mode 1: pseudo-random content tied to the row address.
   function automatic logic [PW-1:0] ref_pix(input int mode, input logic [31:0] sd,
                                             input logic [AW-1:0] a, input int k);
      logic [31:0] h;
      if (mode == 0) return PW'(k);
      h = (32'(a) * 32'd2654435761) ^ (32'(k) * 32'h0000_9E37) ^ sd;
      return h[PW-1:0] ^ h[31:8];
   endfunction

   always_comb begin
      read_data = '0;
      if (read_enable)
         for (int k = 0; k < DW; k++) read_data[k*PW +: PW] = ref_pix(data_mode, seed, address, k);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      hs_pix.delete(); hs_lr.delete(); hs_lf.delete(); hs_cyc.delete();
      rd_addr.delete(); done_cyc.delete();
      re_cnt = 0; valid_cnt = 0; first_valid_cyc = -1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      pix_ready = (ready_mode == 0) ? 1'b1 : (($urandom % 3) != 0);
   end

   // Monitor: logs stream/SRAM activity and checks that stalled outputs hold.
   initial begin
      logic          prev_stall, prev_re, prev_rst, prev_lr, prev_lf;
      logic [PW-1:0] prev_pix;
      prev_stall = 1'b0; prev_re = 1'b0; prev_rst = 1'b1;
      prev_lr = 1'b0; prev_lf = 1'b0; prev_pix = '0;
      clear_logs();
      forever begin
         @(negedge clk);
         if (prev_stall && !prev_rst) begin
            chk("stall_valid", 64'(pix_valid), 64'd1);
            chk("stall_data", 64'(pix_data), 64'(prev_pix));
            chk("stall_last_row", 64'(pix_last_row), 64'(prev_lr));
            chk("stall_last_frame", 64'(pix_last_frame), 64'(prev_lf));
         end
         if (pix_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (pix_valid && pix_ready) begin
            hs_pix.push_back(pix_data); hs_lr.push_back(pix_last_row);
            hs_lf.push_back(pix_last_frame); hs_cyc.push_back(cyc);
         end
         if (read_enable) begin
            re_cnt++;
            if (!prev_re) rd_addr.push_back(address);
         end
         if (done) begin
            done_cyc.push_back(cyc);
            chk("busy_at_done", 64'(busy), 64'd0);
         end
         prev_stall = pix_valid && !pix_ready;
         prev_pix = pix_data; prev_lr = pix_last_row; prev_lf = pix_last_frame;
         prev_re = read_enable; prev_rst = rst;
      end
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 64'(pix_valid), 64'd0);
      chk({tag, "_re"}, 64'(read_enable), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_data"}, 64'(pix_data), 64'd0);
      chk({tag, "_addr"}, 64'(address), 64'd0);
      chk({tag, "_flags"}, 64'({pix_last_row, pix_last_frame}), 64'd0);
   endtask

   task automatic run_frame(input logic [AW-1:0] base, input int n, input int mode,
                            input int rmode, input int second_at, input logic [AW-1:0] second_base);
      int s, budget, nexp, lr_cnt, lf_cnt;
      logic [AW-1:0] exp_addr[$];
      logic [PW-1:0] exp_pix[$];
      bit exp_lr[$], exp_lf[$];
      clear_logs();
      data_mode = mode; ready_mode = rmode;
      @(posedge clk); #1;
      start = 1'b1; base_address = base; num_rows = 16'(n); s = cyc;
      budget = n * DW * 6 + 40;
      for (int k = 1; k <= budget && done_cyc.size() == 0; k++) begin
         @(posedge clk); #1;
         start = (second_at != 0 && k == second_at);
         if (start) begin base_address = second_base; num_rows = 16'(n + 1); end
         if (k == 1) chk("busy_after_start", 64'(busy), 64'(n != 0));
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", 64'(done_cyc.size()), 64'd1);
      chk("busy_after_done", 64'(busy), 64'd0);

      for (int r = 0; r < n; r++) begin
         exp_addr.push_back(AW'(32'(base) + 32'(r * STRIDE)));
         for (int k = 0; k < DW; k++) begin
            exp_pix.push_back(ref_pix(mode, seed, exp_addr[r], k));
            exp_lr.push_back(k == DW - 1);
            exp_lf.push_back(k == DW - 1 && r == n - 1);
         end
      end
      nexp = n * DW;
      chk("handshakes", 64'(hs_pix.size()), 64'(nexp));
      chk("read_rows", 64'(rd_addr.size()), 64'(n));
      chk("read_cycles", 64'(re_cnt), 64'(n));
      for (int i = 0; i < n && i < rd_addr.size(); i++) chk("row_addr", 64'(rd_addr[i]), 64'(exp_addr[i]));
      lr_cnt = 0; lf_cnt = 0;
      for (int i = 0; i < nexp && i < hs_pix.size(); i++) begin
         chk("pix_data", 64'(hs_pix[i]), 64'(exp_pix[i]));
         chk("pix_last_row", 64'(hs_lr[i]), 64'(exp_lr[i]));
         chk("pix_last_frame", 64'(hs_lf[i]), 64'(exp_lf[i]));
         lr_cnt += int'(hs_lr[i]); lf_cnt += int'(hs_lf[i]);
      end
      chk("last_row_count", 64'(lr_cnt), 64'(n));
      chk("last_frame_count", 64'(lf_cnt), 64'(n != 0));
      if (n == 0) begin
         chk("empty_valid_cycles", 64'(valid_cnt), 64'd0);
         chk("empty_done_latency", 64'(done_cyc.size() > 0 ? done_cyc[0] - s : -1), 64'd1);
      end else begin
         chk("first_valid_latency", 64'(first_valid_cyc - s), 64'd2);
         if (rmode == 0) begin
            chk("done_latency", 64'(done_cyc.size() > 0 ? done_cyc[0] - s : -1), 64'(n * (DW + 1) + 1));
            if (hs_cyc.size() == nexp)
               chk("last_pixel_cycle", 64'(hs_cyc[nexp-1] - s), 64'(n * (DW + 1)));
         end
      end
   endtask

   initial begin
      seed = $urandom;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      rst = 1'b0;

      // Abort mid-stream with a 3-cycle reset.
      clear_logs();
      ready_mode = 0; data_mode = 1;
      @(posedge clk); #1;
      start = 1'b1; base_address = 24'h001000; num_rows = 16'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("pre_abort_valid", 64'(pix_valid), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_idle("abort");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle("post_abort");
      chk("abort_no_done", 64'(done_cyc.size()), 64'd0);

      run_frame(24'h000100, 1, 0, 0, 0, '0);
      run_frame(24'h000000, 3, 1, 0, 0, '0);
      run_frame(AW'($urandom), 3, 1, 1, 0, '0);
      run_frame(24'hFFFF80, 2, 1, 1, 0, '0);
      run_frame(24'h000500, 0, 1, 0, 0, '0);
      run_frame(24'h002000, 2, 1, 0, 10, 24'h009000);
      run_frame(24'h003000, 2, 1, 0, 2 * (DW + 1) + 1, 24'h007000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
